// File: rtl/wormhole_switch_allocator.sv
// Wormhole switch allocator: one round-robin arbiter per output, with registered grants.
// Define SA_PACKET_LOCK_EN to hold an output for a whole packet; otherwise arbitration is per flit.
module wormhole_switch_allocator #(
    parameter  int N_IN  = 5,
    parameter  int N_OUT = 5,
    localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_IN-1:0]     req_vld,
    input  logic [N_IN*OW-1:0]  req_port,
    input  logic [N_IN-1:0]     req_tail,
    input  logic [N_OUT-1:0]    out_rdy,
    output logic [N_IN-1:0]     gnt,
    output logic [N_OUT-1:0]    out_vld,
    output logic [N_OUT*IW-1:0] out_sel
);

    logic [IW-1:0]     ptr_r     [N_OUT];
    logic [N_IN-1:0]   gnt_r;
    logic [N_OUT-1:0]  out_vld_r;
    logic [N_OUT*IW-1:0] out_sel_r;

    logic [N_IN-1:0]   elig_s    [N_OUT];
    logic [N_OUT-1:0]  win_vld_s;
    logic [IW-1:0]     win_idx_s [N_OUT];
    logic [IW-1:0]     ptr_nxt_s [N_OUT];
    logic [N_OUT-1:0]  grant_s;
    logic [N_IN-1:0]   gnt_nxt_s;

`ifdef SA_PACKET_LOCK_EN
    logic [N_OUT-1:0]  lock_vld_r;
    logic [IW-1:0]     lock_in_r [N_OUT];
    logic [N_OUT-1:0]  win_tail_s;
`else
    logic              unused_tail_s;
    assign unused_tail_s = ^req_tail;
`endif

    // (base + k) mod N_IN, with both operands already below N_IN
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        return (sum >= N_IN) ? IW'(sum - N_IN) : IW'(sum);
    endfunction

    // Requesters eligible for each output; an out-of-range port never matches any j
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                elig_s[j][i] = req_vld[i] && (req_port[i*OW +: OW] == OW'(j));
`ifdef SA_PACKET_LOCK_EN
                elig_s[j][i] = elig_s[j][i] && (!lock_vld_r[j] || (lock_in_r[j] == IW'(i)));
`endif
            end
        end
    end

    // Round-robin pick: first eligible input at or after ptr, wrapping
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            win_vld_s[j] = 1'b0;
            win_idx_s[j] = '0;
            for (int k = 0; k < N_IN; k++) begin
                win_idx_s[j] = (!win_vld_s[j] && elig_s[j][wrap_add(ptr_r[j], k)]) ?
                               wrap_add(ptr_r[j], k) : win_idx_s[j];
                win_vld_s[j] = win_vld_s[j] || elig_s[j][wrap_add(ptr_r[j], k)];
            end
            grant_s[j]   = win_vld_s[j] && out_rdy[j];
            ptr_nxt_s[j] = wrap_add(win_idx_s[j], 1);
`ifdef SA_PACKET_LOCK_EN
            win_tail_s[j] = req_tail[win_idx_s[j]];
`endif
        end
    end

    // Per-input grant is the OR of every output that picked that input
    always_comb begin
        gnt_nxt_s = '0;
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                gnt_nxt_s[i] = gnt_nxt_s[i] | (grant_s[j] && (win_idx_s[j] == IW'(i)));
            end
        end
    end

    // Registered grant outputs and round-robin pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_r     <= '0;
            out_vld_r <= '0;
            out_sel_r <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                ptr_r[j] <= '0;
            end
        end else begin
            gnt_r     <= gnt_nxt_s;
            out_vld_r <= grant_s;
            for (int j = 0; j < N_OUT; j++) begin
                out_sel_r[j*IW +: IW] <= grant_s[j] ? win_idx_s[j] : '0;
`ifdef SA_PACKET_LOCK_EN
                if (grant_s[j] && win_tail_s[j]) begin
`else
                if (grant_s[j]) begin
`endif
                    ptr_r[j] <= ptr_nxt_s[j];
                end
            end
        end
    end

`ifdef SA_PACKET_LOCK_EN
    // Packet lock: a head claims the output, the tail releases it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_vld_r <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                lock_in_r[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (grant_s[j]) begin
                    lock_vld_r[j] <= !win_tail_s[j];
                    lock_in_r[j]  <= win_idx_s[j];
                end
            end
        end
    end
`endif

    assign gnt     = gnt_r;
    assign out_vld = out_vld_r;
    assign out_sel = out_sel_r;

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Directed self-checking bench for wormhole_switch_allocator (N_IN=N_OUT=5).
module tb_wormhole_switch_allocator;

    localparam int OW = 3;
    localparam int IW = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  req_vld = '0;
    logic [14:0] req_port = '0;
    logic [4:0]  req_tail = '0;
    logic [4:0]  out_rdy = '0;
    logic [4:0]  gnt;
    logic [4:0]  out_vld;
    logic [14:0] out_sel;

    int n_pass = 0;
    int n_total = 0;

    wormhole_switch_allocator dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_port(req_port),
        .req_tail(req_tail), .out_rdy(out_rdy), .gnt(gnt), .out_vld(out_vld),
        .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    task automatic set_port(input int i, input logic [2:0] p);
        req_port[i*OW +: OW] = p;
    endtask

    task automatic do_reset();
        req_vld = '0; req_tail = '0; req_port = '0; out_rdy = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_vld = 5'b11111; req_tail = 5'b11111; req_port = '0; out_rdy = 5'b11111;
        @(posedge clk); #1;
        n_total++; if (gnt !== 5'b00000) $display("FAIL reset_gnt: got %b want %b", gnt, 5'b00000); else n_pass++;
        n_total++; if (out_vld !== 5'b00000) $display("FAIL reset_out_vld: got %b want %b", out_vld, 5'b00000); else n_pass++;
        n_total++; if (out_sel !== 15'd0) $display("FAIL reset_out_sel: got %h want %h", out_sel, 15'd0); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++; if (gnt !== 5'b00001) $display("FAIL reset_prio_gnt: got %b want %b", gnt, 5'b00001); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_sel [4];
        logic [4:0] exp_g [4];
        exp_sel = '{3'd0, 3'd2, 3'd4, 3'd0};
        exp_g   = '{5'b00001, 5'b00100, 5'b10000, 5'b00001};
        do_reset();
        set_port(0, 3'd1); set_port(2, 3'd1); set_port(4, 3'd1);
        req_vld = 5'b10101; req_tail = 5'b11111; out_rdy = 5'b11111;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_total++; if (out_vld !== 5'b00010) $display("FAIL rr_out_vld c%0d: got %b want %b", c, out_vld, 5'b00010); else n_pass++;
            n_total++; if (out_sel[1*IW +: IW] !== exp_sel[c]) $display("FAIL rr_out_sel c%0d: got %0d want %0d", c, out_sel[1*IW +: IW], exp_sel[c]); else n_pass++;
            n_total++; if (gnt !== exp_g[c]) $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, exp_g[c]); else n_pass++;
        end
    endtask

    task automatic test_lock();
        logic [4:0] exp_g [5];
`ifdef SA_PACKET_LOCK_EN
        exp_g = '{5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b00010};
`else
        exp_g = '{5'b01000, 5'b00010, 5'b01000, 5'b00010, 5'b01000};
`endif
        do_reset();
        set_port(3, 3'd0); set_port(1, 3'd0);
        req_vld = 5'b01000; req_tail = 5'b00010; out_rdy = 5'b11111;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_total++; if (gnt !== exp_g[c]) $display("FAIL lock_gnt c%0d: got %b want %b", c, gnt, exp_g[c]); else n_pass++;
            n_total++; if (out_vld[0] !== 1'b1) $display("FAIL lock_out_vld c%0d: got %b want 1", c, out_vld[0]); else n_pass++;
            if (c == 0) req_vld = 5'b01010;
            if (c == 2) req_tail = 5'b01010;
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_g [7];
`ifdef SA_PACKET_LOCK_EN
        exp_g = '{5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b01000};
`else
        exp_g = '{5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b00010, 5'b01000};
`endif
        do_reset();
        set_port(1, 3'd2); set_port(3, 3'd2);
        req_vld = 5'b00010; req_tail = 5'b00000; out_rdy = 5'b11111;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            n_total++; if (gnt !== exp_g[c]) $display("FAIL bp_gnt c%0d: got %b want %b", c, gnt, exp_g[c]); else n_pass++;
            n_total++; if (out_vld[2] !== (|exp_g[c])) $display("FAIL bp_out_vld c%0d: got %b want %b", c, out_vld[2], |exp_g[c]); else n_pass++;
            if (c == 0) begin
                req_vld = 5'b01010; req_tail = 5'b01000; out_rdy = 5'b11011;
            end
            if (c == 3) out_rdy = 5'b11111;
            if (c == 4) req_tail = 5'b01010;
        end
    endtask

    task automatic test_parallel();
        do_reset();
        for (int i = 0; i < 5; i++) set_port(i, 3'(4 - i));
        req_vld = 5'b11111; req_tail = 5'b11111; out_rdy = 5'b11111;
        @(posedge clk); #1;
        n_total++; if (gnt !== 5'b11111) $display("FAIL par_gnt: got %b want %b", gnt, 5'b11111); else n_pass++;
        n_total++; if (out_vld !== 5'b11111) $display("FAIL par_out_vld: got %b want %b", out_vld, 5'b11111); else n_pass++;
        n_total++; if (out_sel !== {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}) $display("FAIL par_out_sel: got %h want %h", out_sel, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}); else n_pass++;
        out_rdy = 5'b10101;
        @(posedge clk); #1;
        n_total++; if (gnt !== 5'b10101) $display("FAIL par_rdy_gnt: got %b want %b", gnt, 5'b10101); else n_pass++;
        n_total++; if (out_vld !== 5'b10101) $display("FAIL par_rdy_out_vld: got %b want %b", out_vld, 5'b10101); else n_pass++;
    endtask

    task automatic test_bad_port();
        do_reset();
        set_port(0, 3'd5); set_port(1, 3'd7); set_port(2, 3'd0);
        req_vld = 5'b00111; req_tail = 5'b11111; out_rdy = 5'b11111;
        @(posedge clk); #1;
        n_total++; if (gnt !== 5'b00100) $display("FAIL badport_gnt: got %b want %b", gnt, 5'b00100); else n_pass++;
        n_total++; if (out_vld !== 5'b00001) $display("FAIL badport_out_vld: got %b want %b", out_vld, 5'b00001); else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_port(2, 3'd3);
        req_vld = 5'b00100; req_tail = 5'b00000; out_rdy = 5'b11111;
        @(posedge clk); #1;
        n_total++; if (gnt !== 5'b00100) $display("FAIL rmid_head_gnt: got %b want %b", gnt, 5'b00100); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (gnt !== 5'b00000) $display("FAIL rmid_async_gnt: got %b want %b", gnt, 5'b00000); else n_pass++;
        n_total++; if (out_vld !== 5'b00000) $display("FAIL rmid_async_out_vld: got %b want %b", out_vld, 5'b00000); else n_pass++;
        set_port(0, 3'd3); set_port(4, 3'd3);
        req_vld = 5'b10101; req_tail = 5'b10001;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++; if (gnt !== 5'b00001) $display("FAIL rmid_gnt: got %b want %b", gnt, 5'b00001); else n_pass++;
        n_total++; if (out_vld[3] !== 1'b1) $display("FAIL rmid_out_vld: got %b want 1", out_vld[3]); else n_pass++;
        n_total++; if (out_sel[3*IW +: IW] !== 3'd0) $display("FAIL rmid_out_sel: got %0d want 0", out_sel[3*IW +: IW]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_parallel();
        test_bad_port();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
